// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types: PC-select source, pipeline controller
// state and the packed stage-control patterns used by pipeline_ctrl.
// Control vector bit order (msb..lsb):
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//   exmem_en, exmem_flush, memwb_en, memwb_flush
package cpu_types_pkg;
  typedef enum logic [1:0] {NEXT, BRANCH, JUMP, JR} pc_select_t;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} pipe_ctrl_state_t;
  localparam logic [8:0] CTL_NORMAL = 9'b110101010;
  localparam logic [8:0] CTL_RESET  = 9'b001010101;
  localparam logic [8:0] CTL_HALT   = 9'b000000000;
  localparam logic [8:0] CTL_MEMSTL = 9'b000000011;
  localparam logic [8:0] CTL_REDIR  = 9'b111111110;
  localparam logic [8:0] CTL_LDUSE  = 9'b000111010;
  localparam logic [8:0] CTL_FETCH  = 9'b011101010;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard status from the pipeline and stage control back.
// master: pipeline side (drives status, receives enables/flushes/counters)
// slave : controller side (pipeline_ctrl)
interface pipeline_ctrl_if #(parameter int CNTW = 16);
  import cpu_types_pkg::*;
  logic ihit, dhit, dREN_mem, dWEN_mem, halt_mem, dREN_ex, rt_used_id;
  pc_select_t pc_select_mem;
  logic [4:0] wsel_ex, rs_id, rt_id;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, halt_mem, dREN_ex, rt_used_id,
           pc_select_mem, wsel_ex, rs_id, rt_id,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halted,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, halt_mem, dREN_ex, rt_used_id,
           pc_select_mem, wsel_ex, rs_id, rt_id,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports: CLK, RST (async, active-high), inc (count this cycle),
//        clear (sync clear), q (count value).
module sat_counter #(parameter int width = 16) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clear,
  output logic [width-1:0] q
);
  always_ff @(posedge CLK or posedge RST)
    if (RST) q <= '0;
    else if (clear) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage pipeline.
// Ports: CLK, RST (async, active-high), bus (pipeline_ctrl_if.slave):
//   status in  : ihit, dhit, dREN/dWEN_mem, pc_select_mem, halt_mem,
//                dREN_ex, wsel_ex, rs_id, rt_id, rt_used_id
//   control out: per-latch *_en / *_flush, halted, stall_cnt, flush_cnt
module pipeline_ctrl #(parameter int CNTW = 16) (
  input  logic CLK,
  input  logic RST,
  pipeline_ctrl_if.slave bus
);
  import cpu_types_pkg::*;
  pipe_ctrl_state_t state, state_n;
  logic ihit_pend, ihit_pend_n, halted_q;
  logic mem_stall, dw_done, redirect, load_use, fetch_stall;
  logic [8:0] ctl;
  always_comb begin
    mem_stall   = state != HALTED && (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
    dw_done     = state == DWAIT && !mem_stall;
    redirect    = bus.pc_select_mem != NEXT;
    load_use    = bus.dREN_ex && bus.wsel_ex != 5'd0 &&
                  (bus.wsel_ex == bus.rs_id || (bus.rt_used_id && bus.wsel_ex == bus.rt_id));
    fetch_stall = !(bus.ihit || ihit_pend);
    // a finished data access releases the whole pipe for one cycle
    ctl = RST            ? CTL_RESET  :
          state == HALTED ? CTL_HALT   :
          mem_stall      ? CTL_MEMSTL :
          dw_done        ? CTL_NORMAL :
          redirect       ? CTL_REDIR  :
          load_use       ? CTL_LDUSE  :
          fetch_stall    ? CTL_FETCH  : CTL_NORMAL;
    state_n = state == HALTED ? HALTED :
              mem_stall       ? DWAIT  :
              bus.halt_mem    ? HALTED : RUN;
    // remember a fetch that completed while frozen so it is not lost
    ihit_pend_n = ctl[8] ? 1'b0 : state == DWAIT ? (ihit_pend || bus.ihit) : ihit_pend;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= RUN;
      ihit_pend <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_n;
      ihit_pend <= ihit_pend_n;
      halted_q  <= state_n == HALTED;
    end
  assign {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
          bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush} = ctl;
  assign bus.halted = halted_q;
  sat_counter #(.width(CNTW)) u_stall (
    .CLK(CLK), .RST(RST), .inc(!ctl[8] && state != HALTED), .clear(1'b0), .q(bus.stall_cnt)
  );
  sat_counter #(.width(CNTW)) u_flush (
    .CLK(CLK), .RST(RST), .inc(ctl == CTL_REDIR), .clear(1'b0), .q(bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl (CNTW=16 and CNTW=4).
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;
  localparam logic [8:0] V_NORM = 9'b110101010;
  localparam logic [8:0] V_RST  = 9'b001010101;
  localparam logic [8:0] V_HALT = 9'b000000000;
  localparam logic [8:0] V_MEM  = 9'b000000011;
  localparam logic [8:0] V_REDR = 9'b111111110;
  localparam logic [8:0] V_LDU  = 9'b000111010;
  localparam logic [8:0] V_FET  = 9'b011101010;
  typedef struct {
    logic [8:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        h;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  exp_t sb[$];
  pipeline_ctrl_if #(.CNTW(16)) bus();
  pipeline_ctrl_if #(.CNTW(4))  bus2();
  pipeline_ctrl #(.CNTW(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  pipeline_ctrl #(.CNTW(4))  dut4 (.CLK(CLK), .RST(RST), .bus(bus2));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge CLK)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctl", {23'b0, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush}, {23'b0, e.ctl});
      chk("stall_cnt", {16'b0, bus.stall_cnt}, {16'b0, e.sc});
      chk("flush_cnt", {16'b0, bus.flush_cnt}, {16'b0, e.fc});
      chk("halted", {31'b0, bus.halted}, {31'b0, e.h});
    end
  task automatic drv(input logic ih, dh, dr, dw, input pc_select_t ps, input logic hl, dre,
                     input logic [4:0] ws, rs, rt, input logic ru);
    bus.ihit = ih; bus.dhit = dh; bus.dREN_mem = dr; bus.dWEN_mem = dw;
    bus.pc_select_mem = ps; bus.halt_mem = hl; bus.dREN_ex = dre;
    bus.wsel_ex = ws; bus.rs_id = rs; bus.rt_id = rt; bus.rt_used_id = ru;
  endtask
  task automatic idle();
    drv(1, 0, 0, 0, NEXT, 0, 0, 0, 0, 0, 0);
  endtask
  // push the expectation for this cycle, let the monitor compare, advance
  task automatic cyc(input logic [8:0] v, input logic h);
    exp_t e;
    if (RST) begin
      exp_stall = 0;
      exp_flush = 0;
    end
    e.ctl = v; e.sc = exp_stall[15:0]; e.fc = exp_flush[15:0]; e.h = RST ? 1'b0 : h;
    sb.push_back(e);
    if (!RST) begin
      if (!v[8] && !h) exp_stall++;
      if (v == V_REDR) exp_flush++;
    end
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask
  initial begin
    bus2.ihit = 0; bus2.dhit = 0; bus2.dREN_mem = 0; bus2.dWEN_mem = 0;
    bus2.pc_select_mem = NEXT; bus2.halt_mem = 0; bus2.dREN_ex = 0;
    bus2.wsel_ex = 0; bus2.rs_id = 0; bus2.rt_id = 0; bus2.rt_used_id = 0;
    idle();
    RST = 1;
    #1;
    cyc(V_RST, 0);
    cyc(V_RST, 0);
    RST = 0;
    idle();                                    cyc(V_NORM, 0);
    drv(1, 0, 0, 0, NEXT, 0, 1, 5, 5, 0, 0);   cyc(V_LDU, 0);
    idle();                                    cyc(V_NORM, 0);
    drv(1, 0, 0, 0, NEXT, 0, 1, 5, 3, 5, 1);   cyc(V_LDU, 0);
    drv(1, 0, 0, 0, NEXT, 0, 1, 5, 3, 5, 0);   cyc(V_NORM, 0);
    drv(1, 0, 0, 0, NEXT, 0, 1, 0, 0, 0, 0);   cyc(V_NORM, 0);
    drv(1, 0, 0, 0, NEXT, 0, 0, 5, 5, 0, 0);   cyc(V_NORM, 0);
    drv(0, 0, 0, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_FET, 0);
    drv(0, 0, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_MEM, 0);
    drv(1, 0, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_MEM, 0);
    drv(0, 0, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_MEM, 0);
    drv(0, 1, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_NORM, 0);
    drv(0, 0, 0, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_FET, 0);
    idle();                                    cyc(V_NORM, 0);
    drv(1, 0, 0, 1, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_MEM, 0);
    drv(1, 1, 0, 1, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_NORM, 0);
    drv(1, 0, 0, 0, BRANCH, 0, 1, 5, 5, 0, 0); cyc(V_REDR, 0);
    idle();                                    cyc(V_NORM, 0);
    drv(0, 0, 0, 0, JUMP, 0, 0, 0, 0, 0, 0);   cyc(V_REDR, 0);
    drv(1, 0, 1, 0, BRANCH, 0, 0, 0, 0, 0, 0); cyc(V_MEM, 0);
    drv(1, 1, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_NORM, 0);
    drv(1, 0, 1, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_MEM, 0);
    cyc(V_MEM, 0);
    RST = 1;                                   cyc(V_RST, 0);
    RST = 0;
    drv(0, 0, 0, 0, NEXT, 0, 0, 0, 0, 0, 0);   cyc(V_FET, 0);
    idle();                                    cyc(V_NORM, 0);
    drv(1, 0, 0, 0, NEXT, 1, 0, 0, 0, 0, 0);   cyc(V_NORM, 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 1, 0, BRANCH, 0, 1, 5, 5, 0, 0);
      cyc(V_HALT, 1);
    end
    RST = 1;                                   cyc(V_RST, 0);
    RST = 0;
    idle();                                    cyc(V_NORM, 0);
    chk("sat4_first", {28'b0, bus2.stall_cnt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      idle();
      cyc(V_NORM, 0);
      chk("sat4", {28'b0, bus2.stall_cnt}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
    end
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
